award_spawn_ctrl: RTL

Upstream controller for the award square. Decides when and where the award appears: waits a programmable number of frames, draws a random on-grid cell from a free-running LFSR, and pulses `up` together with a stable `randomX`/`randomY`. It then watches the players' `take1`/`take2` collision strobes. On a take it issues a one-cycle bonus to the winning player and restarts the wait. If nobody takes the award within its lifetime, it relocates the award.

---
 rtl/award_spawn_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/award_spawn_ctrl.sv
// Award spawn controller: waits a frame delay, draws an on-grid cell from an LFSR,
// shows the award, then grants a bonus on a take or relocates it when its lifetime expires.
module award_spawn_ctrl #(
  parameter int          SPAWN_DELAY_FRAMES = 180,
  parameter int          LIFETIME_FRAMES    = 600,
  parameter int          MAX_CELL_X         = 16,
  parameter int          MAX_CELL_Y         = 11,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       take1,
  input  logic       take2,
  output logic [4:0] randomX,
  output logic [4:0] randomY,
  output logic       up,
  output logic       awardActive,
  output logic       bonus1,
  output logic       bonus2,
  output logic [3:0] takeCount1,
  output logic [3:0] takeCount2
);

  localparam logic [9:0] SPAWN_LOAD = 10'(SPAWN_DELAY_FRAMES);
  localparam logic [9:0] LIFE_LOAD  = 10'(LIFETIME_FRAMES);
  localparam logic [4:0] MAX_X      = 5'(MAX_CELL_X);
  localparam logic [4:0] MAX_Y      = 5'(MAX_CELL_Y);

  // WAIT: spawn delay | PICK: draw cell | SHOW: up pulse | VISIBLE: takeable
  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_PICK    = 2'd1,
    S_SHOW    = 2'd2,
    S_VISIBLE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [9:0]  cnt, cnt_nxt;
  logic [2:0]  retry, retry_nxt;
  logic [4:0]  x_nxt, y_nxt;
  logic [4:0]  cand_x, cand_y;
  logic        x_ok, y_ok;
  logic        bonus1_nxt, bonus2_nxt;
  logic [3:0]  tc1_nxt, tc2_nxt;

  assign cand_x = lfsr[4:0];
  assign cand_y = lfsr[9:5];
  assign x_ok   = (cand_x <= MAX_X);
  assign y_ok   = (cand_y <= MAX_Y);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    retry_nxt  = retry;
    x_nxt      = randomX;
    y_nxt      = randomY;
    bonus1_nxt = 1'b0;
    bonus2_nxt = 1'b0;
    tc1_nxt    = takeCount1;
    tc2_nxt    = takeCount2;
    case (state)
      S_WAIT: begin
        if (startOfFrame) begin
          if (cnt <= 10'd1) state_nxt = S_PICK;
          else              cnt_nxt   = cnt - 10'd1;
        end
      end
      S_PICK: begin
        if (x_ok && y_ok) begin
          x_nxt     = cand_x;
          y_nxt     = cand_y;
          retry_nxt = 3'd0;
          state_nxt = S_SHOW;
        end else if (retry == 3'd7) begin
          // Bounded pick time: force the stubborn coordinate(s) onto the grid edge.
          x_nxt     = x_ok ? cand_x : MAX_X;
          y_nxt     = y_ok ? cand_y : MAX_Y;
          retry_nxt = 3'd0;
          state_nxt = S_SHOW;
        end else begin
          retry_nxt = retry + 3'd1;
        end
      end
      S_SHOW: begin
        cnt_nxt   = LIFE_LOAD;
        state_nxt = S_VISIBLE;
      end
      S_VISIBLE: begin
        if (take1) begin
          bonus1_nxt = 1'b1;
          if (takeCount1 != 4'hF) tc1_nxt = takeCount1 + 4'd1;
          cnt_nxt    = SPAWN_LOAD;
          state_nxt  = S_WAIT;
        end else if (take2) begin
          bonus2_nxt = 1'b1;
          if (takeCount2 != 4'hF) tc2_nxt = takeCount2 + 4'd1;
          cnt_nxt    = SPAWN_LOAD;
          state_nxt  = S_WAIT;
        end else if (startOfFrame) begin
          if (cnt <= 10'd1) state_nxt = S_PICK;
          else              cnt_nxt   = cnt - 10'd1;
        end
      end
      default: begin
        cnt_nxt   = SPAWN_LOAD;
        state_nxt = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_WAIT;
      cnt         <= SPAWN_LOAD;
      retry       <= 3'd0;
      lfsr        <= LFSR_SEED;
      randomX     <= 5'd0;
      randomY     <= 5'd0;
      up          <= 1'b0;
      awardActive <= 1'b0;
      bonus1      <= 1'b0;
      bonus2      <= 1'b0;
      takeCount1  <= 4'd0;
      takeCount2  <= 4'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      randomX     <= x_nxt;
      randomY     <= y_nxt;
      up          <= (state_nxt == S_SHOW);
      awardActive <= (state_nxt == S_VISIBLE);
      bonus1      <= bonus1_nxt;
      bonus2      <= bonus2_nxt;
      takeCount1  <= tc1_nxt;
      takeCount2  <= tc2_nxt;
    end
  end

endmodule
